// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Frame constants and FSM state encodings shared by the UART slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 receiver with 2-flop input synchronizer and mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES  = 434,
    parameter int HALF_CYCLES = 217
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done
);

    localparam int                c_CNT_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_CYCLES - 1);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    rx_state_t            r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= {2{IDLE_LEVEL}};
            r_rx_prev <= IDLE_LEVEL;
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
            rx_done   <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (r_rx_prev && !w_rx) r_state <= R_START;
                end
                R_START: begin
                    // A line that is high again at mid-start-bit was only a glitch
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_rx ? R_IDLE : R_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= R_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= R_IDLE;
                        if (w_rx) begin
                            rx_data <= r_shift;
                            rx_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 transmitter, registered tx line, BIT_CYCLES clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int                 c_CNT_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(BIT_CYCLES - 1);

    tx_state_t            r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    assign tx_busy = (r_state != T_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= T_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            tx        <= IDLE_LEVEL;
        end else begin
            case (r_state)
                T_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    tx        <= IDLE_LEVEL;
                    if (tx_start) begin
                        r_shift <= tx_data;
                        tx      <= ~IDLE_LEVEL;
                        r_state <= T_START;
                    end
                end
                T_START: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        tx      <= r_shift[0];
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_state <= T_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            tx        <= IDLE_LEVEL;
                            r_state   <= T_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            tx        <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                T_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= T_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= T_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart.sv
`default_nettype none
// ============================================================================
// Module   : uart
// Brief    : Loopback echo UART: received bytes pass through a one-entry
//            holding register and are retransmitted unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx
);

    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;

    logic [DATA_BITS-1:0] w_rx_data;
    logic                 w_rx_done;
    logic                 w_tx_busy;
    logic                 w_load;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_valid;

    uart_rx #(
        .BIT_CYCLES (BIT_CYCLES),
        .HALF_CYCLES(HALF_CYCLES)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_data(w_rx_data),
        .rx_done(w_rx_done)
    );

    assign w_load = r_hold_valid && !w_tx_busy;

    uart_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_data (r_hold_data),
        .tx_start(w_load),
        .tx      (tx),
        .tx_busy (w_tx_busy)
    );

    // A fresh byte takes priority over the transmitter's load: newest wins and stays valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_rx_done) begin
            r_hold_data  <= w_rx_data;
            r_hold_valid <= 1'b1;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart
// Brief    : Self-checking bench for the loopback UART; a line-level tx decoder
//            collects echoed frames that each scenario compares to its model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int BIT      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    bit         mon_ok[$];
    int         mon_starts = 0;
    int         mon_last_t = 0;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .tx (tx)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decodes every frame on tx; each bit must hold its level for exactly BIT cycles
    initial begin : tx_monitor
        logic       prev;
        logic [9:0] bits;
        bit         good;
        bit         aborted;
        int         t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                mon_starts++;
                mon_last_t = t0;
                good    = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int i = 0; i < 10 && !aborted; i++) begin
                    for (int c = 0; c < BIT; c++) begin
                        if (i != 0 || c != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[i] = tx;
                        else if (tx !== bits[i]) good = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) good = 1'b0;
                    mon_q.push_back(bits[8:1]);
                    mon_t.push_back(t0);
                    mon_ok.push_back(good);
                end
            end
            prev = tx;
        end
    end

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_bit,
                              output int t_fall);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        t_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (bc) @(negedge clk);
        end
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (mon_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (mon_q.size() >= target);
    endtask

    task automatic test_reset;
        int lows;
        rst = 1'b1;
        rx  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (tx !== 1'b1) begin
                bad++;
                $display("FAIL reset_tx cycle %0d: got %b want 1", i, tx);
            end
        end
        rst  = 1'b0;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL idle_after_reset: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_latency;
        int n0, tf, lat;
        bit ok;
        n0 = mon_q.size();
        send_frame(8'h0F, 450, 1'b1, tf);
        wait_frames(n0 + 1, 10000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL latency_echo: got %0d frames want %0d", mon_q.size(), n0 + 1);
        end else begin
            lat = mon_t[n0] - tf;
            total++;
            if (mon_q[n0] !== 8'h0F) begin
                bad++;
                $display("FAIL latency_byte: got %h want 0f", mon_q[n0]);
            end
            total++;
            if (!mon_ok[n0]) begin
                bad++;
                $display("FAIL latency_shape: got bad frame timing want %0d cycles/bit", BIT);
            end
            total++;
            if (lat < 4120 || lat > 4135) begin
                bad++;
                $display("FAIL latency_cycles: got %0d want 4120..4135", lat);
            end
        end
    endtask

    task automatic test_glitch;
        int n0, s0, tf;
        bit ok;
        n0 = mon_q.size();
        s0 = mon_starts;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        send_frame(8'hC3, BIT, 1'b1, tf);
        wait_frames(n0 + 1, 10000, ok);
        total++;
        if (!ok || mon_q[n0] !== 8'hC3) begin
            bad++;
            $display("FAIL glitch_follow: got %0d frames/%h want 1 frame c3",
                     mon_q.size() - n0, ok ? mon_q[n0] : 8'hxx);
        end
        total++;
        if (mon_starts - s0 != 1) begin
            bad++;
            $display("FAIL glitch_starts: got %0d tx frames want 1", mon_starts - s0);
        end
    endtask

    task automatic test_framing;
        int n0, s0, tf;
        bit ok;
        n0 = mon_q.size();
        s0 = mon_starts;
        send_frame(8'hA5, BIT, 1'b0, tf);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        send_frame(8'h3C, BIT, 1'b1, tf);
        wait_frames(n0 + 1, 10000, ok);
        total++;
        if (!ok || mon_q[n0] !== 8'h3C) begin
            bad++;
            $display("FAIL framing_follow: got %0d frames/%h want 1 frame 3c",
                     mon_q.size() - n0, ok ? mon_q[n0] : 8'hxx);
        end
        total++;
        if (mon_starts - s0 != 1) begin
            bad++;
            $display("FAIL framing_starts: got %0d tx frames want 1", mon_starts - s0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int n0, tf;
        bit ok;
        n0 = mon_q.size();
        exp_q = '{8'h01, 8'h02, 8'h03};
        foreach (exp_q[k]) send_frame(exp_q[k], BIT, 1'b1, tf);
        wait_frames(n0 + 3, 12000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_count: got %0d frames want 3", mon_q.size() - n0);
        end else begin
            foreach (exp_q[k]) begin
                total++;
                if (mon_q[n0+k] !== exp_q[k] || !mon_ok[n0+k]) begin
                    bad++;
                    $display("FAIL b2b_frame%0d: got %h ok=%0d want %h ok=1",
                             k, mon_q[n0+k], mon_ok[n0+k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n0, s0, bc, tf;
        bit good, ok;
        n0 = mon_q.size();
        s0 = mon_starts;
        for (int k = 0; k < 3; k++) begin
            b    = 8'($urandom_range(0, 255));
            bc   = int'($urandom_range(434, 448));
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, bc, good, tf);
            if (good) exp_q.push_back(b);
            rx = 1'b1;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        wait_frames(n0 + exp_q.size(), 10000, ok);
        repeat (20) @(negedge clk);
        total++;
        if (!ok || mon_starts - s0 != exp_q.size()) begin
            bad++;
            $display("FAIL random_count: got %0d frames want %0d", mon_starts - s0, exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                total++;
                if (mon_q[n0+k] !== exp_q[k] || !mon_ok[n0+k]) begin
                    bad++;
                    $display("FAIL random_frame%0d: got %h ok=%0d want %h ok=1",
                             k, mon_q[n0+k], mon_ok[n0+k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_tx;
        int n0, s0, tf, n, target, lows;
        bit ok;
        n0 = mon_q.size();
        s0 = mon_starts;
        send_frame(8'h5A, BIT, 1'b1, tf);
        n = 0;
        while (mon_starts == s0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (mon_starts == s0) begin
            bad++;
            $display("FAIL rstmid_start: got no tx frame want 1");
        end else begin
            // Land in the middle of data bit 4 (line bit index 5)
            target = mon_last_t + 5 * BIT + BIT / 2;
            while (cyc < target) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            total++;
            if (tx !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_tx: got %b want 1", tx);
            end
            repeat (2) @(negedge clk);
            rst  = 1'b0;
            lows = 0;
            repeat (3000) begin
                @(negedge clk);
                if (tx !== 1'b1) lows++;
            end
            total++;
            if (lows != 0 || mon_starts != s0 + 1 || mon_q.size() != n0) begin
                bad++;
                $display("FAIL rstmid_quiet: got %0d low cycles %0d frames want 0 and 0",
                         lows, mon_q.size() - n0);
            end
            send_frame(8'h77, BIT, 1'b1, tf);
            wait_frames(n0 + 1, 10000, ok);
            total++;
            if (!ok || mon_q[n0] !== 8'h77 || !mon_ok[n0]) begin
                bad++;
                $display("FAIL rstmid_next: got %0d frames/%h want 1 frame 77",
                         mon_q.size() - n0, ok ? mon_q[n0] : 8'hxx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_random();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: line rate in bit/s.
REQ-003 Constant BIT_CYCLES = CLK_FREQ/BAUD, truncated (434 at defaults); HALF_CYCLES = BIT_CYCLES/2 (217).
REQ-004 clk  input  1  single system clock, all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial input, idle high.
REQ-007 tx  output  1  serial output, idle high.

Function
REQ-008 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-009 Function is loopback echo: every byte received correctly on rx is retransmitted unchanged on tx.
REQ-010 rx passes through a 2-flop synchronizer; all rx decoding uses the synchronized value.
REQ-011 Receiver FSM states: R_IDLE, R_START, R_DATA, R_STOP.
REQ-012 R_IDLE -> R_START on a synchronized 1->0 transition of rx.
REQ-013 R_START samples rx HALF_CYCLES after the edge.
REQ-014 In R_START, rx=1 is a glitch: return to R_IDLE with no byte delivered.
REQ-015 In R_START, rx=0 moves to R_DATA.
REQ-016 R_DATA samples 8 bits, each BIT_CYCLES after the previous sample, and shifts them in LSB first.
REQ-017 R_STOP samples once more, BIT_CYCLES later.
REQ-018 In R_STOP, stop=1 delivers the byte as a one-cycle rx_done pulse; stop=0 is a framing error and the byte is discarded. Both outcomes return to R_IDLE.
REQ-019 The receiver re-arms in R_IDLE immediately after the stop sample, so back-to-back frames are accepted.
REQ-020 The top level holds one 8-bit holding register with a valid flag.
REQ-021 On rx_done, the byte is written to the holding register.
REQ-022 If the holding register is already valid when a new byte arrives, the new byte overwrites it (newest wins).
REQ-023 Transmitter FSM states: T_IDLE, T_START, T_DATA, T_STOP, each bit lasting exactly BIT_CYCLES clocks.
REQ-024 In T_IDLE with the holding register valid, the transmitter loads the byte and clears valid. tx goes low for the start bit on the next cycle.
REQ-025 If rx_done and the transmitter's load of the holding register occur in the same cycle, the new byte is stored and remains valid.
REQ-026 After the stop bit completes, the transmitter returns to T_IDLE. If valid is set, the next start bit begins on the following cycle.
REQ-027 tx is driven from a register (glitch-free); it is 1 in T_IDLE and T_STOP.
REQ-028 Bit counters are 4 bits wide; the baud counter is $clog2(BIT_CYCLES) bits wide and never wraps past BIT_CYCLES-1.

Reset
REQ-029 While rst=1, both FSMs go to IDLE and the holding register's valid flag is cleared.
REQ-030 While rst=1, tx=1, and all counters and shift registers are 0.
REQ-031 While rst=1, the synchronizer flops are set to 1.
REQ-032 Reset asserted mid-frame aborts that frame; tx returns high on the next clock edge.
REQ-033 No partial byte is transmitted after reset is released.

Structure
REQ-034 Shared package uart_pkg holds the FSM state enums for the receiver and transmitter.
REQ-035 uart_pkg holds the frame constants: DATA_BITS=8, IDLE_LEVEL=1.
REQ-036 The receiver is sub-module uart_rx (outputs rx_data[7:0], rx_done).
REQ-037 The transmitter is sub-module uart_tx (inputs tx_data, tx_start; output tx_busy).
REQ-038 Top-level uart contains only the instances, the holding register and the glue logic between them.

Verification
REQ-039 Reset held 5 cycles, rx=1 -> tx=1 throughout and during reset; no activity.
REQ-040 Frame 0x0F sent at 450 cycles/bit (bits 1,1,1,1,0,0,0,0) -> tx emits 0x0F at 434 cycles/bit. The start bit begins within 4120-4135 cycles of rx falling.
REQ-041 rx low pulse of 100 cycles -> rejected as glitch; tx stays high.
REQ-042 Frame 0xA5 with stop bit=0 -> no transmission; a following valid 0x3C is echoed normally.
REQ-043 Three back-to-back frames 0x01,0x02,0x03 at 434 cycles/bit -> all three echoed in order, each with a full stop bit.
REQ-044 rst pulsed during tx data bit 4 -> tx=1 next cycle; no further transmission until a new frame arrives.
